// File: rtl/ps2_key_event_ctrl.sv
// PS/2 scan-code sequencer: folds E0/F0 prefixes into make/break key events,
// filters typematic repeats, queues events in a show-ahead FIFO and tracks paddle keys.
module ps2_key_event_ctrl #(
    parameter int ADDR_W        = 3,
    parameter int TIMEOUT_CYC   = 1_000_000,
    parameter bit REPEAT_FILTER = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    input  logic       rd_en,
    output logic [9:0] ev_dout,
    output logic       ev_empty,
    output logic       ev_full,
    output logic       overflow,
    output logic       key_w,
    output logic       key_s,
    output logic       key_up,
    output logic       key_dn
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0] BYTE_E0 = 8'hE0;
    localparam logic [7:0] BYTE_F0 = 8'hF0;

    typedef enum logic [1:0] {
        IDLE,
        GOT_E0,
        GOT_F0,
        GOT_E0F0
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic             raw_valid;
    logic [9:0]       raw_ev;
    logic             repeat_hit;
    logic             push;

    logic [8:0]       last_make;
    logic             last_valid;

    logic [9:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]  count;
    logic             do_pop, do_wr;

    // ---------------- prefix sequencer ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        raw_valid = 1'b0;
        raw_ev    = '0;
        if (rx_done_tick) begin
            cnt_nxt = '0;
            case (state)
                IDLE: begin
                    if (rx_data == BYTE_E0)      state_nxt = GOT_E0;
                    else if (rx_data == BYTE_F0) state_nxt = GOT_F0;
                    else begin
                        raw_valid = 1'b1;
                        raw_ev    = {2'b00, rx_data};
                    end
                end
                GOT_E0: begin
                    if (rx_data == BYTE_F0)      state_nxt = GOT_E0F0;
                    else if (rx_data != BYTE_E0) begin
                        raw_valid = 1'b1;
                        raw_ev    = {2'b01, rx_data};
                        state_nxt = IDLE;
                    end
                end
                GOT_F0: begin
                    if (rx_data == BYTE_E0)      state_nxt = GOT_E0F0;
                    else if (rx_data != BYTE_F0) begin
                        raw_valid = 1'b1;
                        raw_ev    = {2'b10, rx_data};
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    if (rx_data != BYTE_E0 && rx_data != BYTE_F0) begin
                        raw_valid = 1'b1;
                        raw_ev    = {2'b11, rx_data};
                        state_nxt = IDLE;
                    end
                end
            endcase
        end else if (state == IDLE) begin
            cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
            // abandoned prefix: drop it silently
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    // ---------------- repeat filter and key flags ----------------
    assign repeat_hit = REPEAT_FILTER && !raw_ev[9] && last_valid
                        && (last_make == raw_ev[8:0]);
    assign push       = raw_valid && !repeat_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_make  <= '0;
            last_valid <= 1'b0;
            key_w      <= 1'b0;
            key_s      <= 1'b0;
            key_up     <= 1'b0;
            key_dn     <= 1'b0;
        end else if (raw_valid) begin
            if (raw_ev[9]) begin
                last_valid <= 1'b0;
            end else if (!repeat_hit) begin
                last_valid <= 1'b1;
                last_make  <= raw_ev[8:0];
            end
            case (raw_ev[8:0])
                9'h01D:  key_w  <= !raw_ev[9];
                9'h01B:  key_s  <= !raw_ev[9];
                9'h175:  key_up <= !raw_ev[9];
                9'h172:  key_dn <= !raw_ev[9];
                default: ;
            endcase
        end
    end

    // ---------------- event FIFO ----------------
    assign ev_empty = (count == '0);
    assign ev_full  = (count == (ADDR_W + 1)'(DEPTH));
    assign do_pop   = rd_en && !ev_empty;
    // a full FIFO still accepts a push when the head leaves on the same edge
    assign do_wr    = push && (!ev_full || do_pop);
    assign ev_dout  = ev_empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= raw_ev;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_wr)  wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && ev_full && !do_pop) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Bench for ps2_key_event_ctrl: directed scenarios plus random byte traffic,
// checked every cycle against a queue-based event model.
module tb_ps2_key_event_ctrl;

    localparam int T     = 16;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rd_en = 1'b0;
    logic [9:0] ev_dout;
    logic       ev_empty, ev_full, overflow;
    logic       key_w, key_s, key_up, key_dn;

    ps2_key_event_ctrl #(
        .ADDR_W        (3),
        .TIMEOUT_CYC   (T),
        .REPEAT_FILTER (1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .rd_en        (rd_en),
        .ev_dout      (ev_dout),
        .ev_empty     (ev_empty),
        .ev_full      (ev_full),
        .overflow     (overflow),
        .key_w        (key_w),
        .key_s        (key_s),
        .key_up       (key_up),
        .key_dn       (key_dn)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // reference model: pending prefix flags, event queue, sticky overflow, keys {w,s,up,dn}
    logic [9:0] q[$];
    bit         m_ext, m_brk, m_ovf;
    bit [3:0]   m_keys;
    int         m_last;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        q.delete();
        m_ext = 0; m_brk = 0; m_ovf = 0; m_keys = '0; m_last = -1;
    endtask

    task automatic model_step(bit tk, logic [7:0] d, bit rd);
        bit         pop, push, was_full;
        logic [9:0] ev;
        push = 0;
        ev   = '0;
        if (tk) begin
            if (d == 8'hE0) m_ext = 1;
            else if (d == 8'hF0) m_brk = 1;
            else begin
                ev = {m_brk, m_ext, d};
                m_ext = 0; m_brk = 0;
                if (ev[8:0] == 9'h01D) m_keys[3] = !ev[9];
                if (ev[8:0] == 9'h01B) m_keys[2] = !ev[9];
                if (ev[8:0] == 9'h175) m_keys[1] = !ev[9];
                if (ev[8:0] == 9'h172) m_keys[0] = !ev[9];
                if (ev[9]) begin
                    m_last = -1;
                    push = 1;
                end else if (m_last != int'(ev[8:0])) begin
                    m_last = int'(ev[8:0]);
                    push = 1;
                end
            end
        end
        was_full = (q.size() == DEPTH);
        pop      = rd && (q.size() > 0);
        if (pop) void'(q.pop_front());
        if (push) begin
            if (!was_full || pop) q.push_back(ev);
            else m_ovf = 1;
        end
    endtask

    task automatic check_model();
        chk("empty", 32'(ev_empty), 32'(q.size() == 0));
        chk("full", 32'(ev_full), 32'(q.size() == DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("keys", 32'({key_w, key_s, key_up, key_dn}), 32'(m_keys));
        if (q.size() > 0) chk("dout", 32'(ev_dout), 32'(q[0]));
    endtask

    task automatic step(bit tk, logic [7:0] d, bit rd);
        @(negedge clk);
        rx_done_tick = tk;
        rx_data      = d;
        rd_en        = rd;
        @(posedge clk);
        model_step(tk, d, rd);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; rx_done_tick = 0; rd_en = 0;
        @(posedge clk);
        @(posedge clk);
        model_reset();
        #1;
        chk("rst_empty", 32'(ev_empty), 32'd1);
        chk("rst_full", 32'(ev_full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_keys", 32'({key_w, key_s, key_up, key_dn}), 32'd0);
        chk("rst_dout", 32'(ev_dout), 32'd0);
        @(negedge clk);
        reset = 0;
    endtask

    task automatic drain();
        repeat (DEPTH + 1) step(0, 8'h00, 1);
    endtask

    initial begin
        int idle;
        logic [7:0] b;
        model_reset();

        do_reset();

        step(1, 8'h1D, 0);
        chk("w_make", 32'(ev_dout), 32'h01D);
        chk("w_held", 32'(key_w), 32'd1);
        step(0, 8'h00, 1);
        chk("w_popped", 32'(ev_empty), 32'd1);
        step(1, 8'hF0, 0);
        step(1, 8'h1D, 1);

        drain();
        step(1, 8'hE0, 0);
        step(1, 8'h75, 0);
        chk("up_make", 32'(ev_dout), 32'h175);
        chk("up_held", 32'(key_up), 32'd1);
        step(1, 8'hE0, 1);
        step(1, 8'hF0, 0);
        step(1, 8'h75, 0);
        chk("up_break", 32'(ev_dout), 32'h375);
        chk("up_rel", 32'(key_up), 32'd0);

        drain();
        step(1, 8'h1B, 0);
        step(1, 8'h1B, 0);
        step(1, 8'h1B, 0);
        chk("s_held", 32'(key_s), 32'd1);
        step(1, 8'hF0, 0);
        step(1, 8'h1B, 0);
        chk("s_rel", 32'(key_s), 32'd0);
        chk("typ_head", 32'(ev_dout), 32'h01B);
        step(0, 8'h00, 1);
        chk("typ_second", 32'(ev_dout), 32'h21B);
        step(0, 8'h00, 1);
        chk("typ_count", 32'(ev_empty), 32'd1);

        step(1, 8'hE0, 0);
        repeat (T + 2) step(0, 8'h00, 0);
        m_ext = 0; m_brk = 0;
        step(1, 8'h72, 0);
        chk("to_event", 32'(ev_dout), 32'h072);
        chk("to_dn", 32'(key_dn), 32'd0);

        drain();
        for (int i = 0; i < 9; i++) begin
            step(1, 8'(8'h10 + i), 0);
            if (i == 7) chk("full_8th", 32'(ev_full), 32'd1);
        end
        chk("ovf_set", 32'(overflow), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("drain_order", 32'(ev_dout), 32'(10'h010 + i));
            step(0, 8'h00, 1);
        end
        chk("drained", 32'(ev_empty), 32'd1);
        step(0, 8'h00, 1);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        for (int i = 0; i < 8; i++) step(1, 8'(8'h20 + i), 0);
        step(1, 8'h28, 1);
        chk("coinc_full", 32'(ev_full), 32'd1);
        chk("coinc_head", 32'(ev_dout), 32'h021);

        step(1, 8'hE0, 0);
        step(1, 8'hF0, 0);
        do_reset();
        step(1, 8'h1D, 0);
        chk("post_rst", 32'(ev_dout), 32'h01D);

        idle = 0;
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 9))
                0: b = 8'hE0;
                1: b = 8'hF0;
                2: b = 8'h1D;
                3: b = 8'h1B;
                4: b = 8'h75;
                5: b = 8'h72;
                default: begin
                    b = 8'($urandom_range(0, 255));
                    if (b == 8'hE0 || b == 8'hF0) b = 8'h33;
                end
            endcase
            if (idle >= 8 || $urandom_range(0, 2) != 0) begin
                step(1, b, $urandom_range(0, 3) == 0);
                idle = 0;
            end else begin
                step(0, 8'h00, $urandom_range(0, 1) == 1);
                idle++;
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
